// File: rtl/alu_muldiv_ctrl_pkg.sv
// Shared encodings for the ALU control / multiply-divide unit:
// main-decoder classes, R-type funct codes, ALU operation codes, sequencer states.
package alu_muldiv_ctrl_pkg;

  // Main-decoder classes carried on aluop
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_LOGI  = 2'b11;

  // R-type funct codes
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // ALU operation codes
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  // Multiply/divide sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // Returns {illegal, op}; unknown R-type funct falls back to add and flags illegal
  function automatic logic [4:0] alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    logic [4:0] r;
    r = {1'b0, OP_ADD};
    case (aluop)
      ALUOP_ADD:  r = {1'b0, OP_ADD};
      ALUOP_SUB:  r = {1'b0, OP_SUB};
      ALUOP_LOGI: r = {1'b0, OP_OR};
      default: begin
        case (funct)
          F_ADD:  r = {1'b0, OP_ADD};
          F_SUB:  r = {1'b0, OP_SUB};
          F_AND:  r = {1'b0, OP_AND};
          F_OR:   r = {1'b0, OP_OR};
          F_XOR:  r = {1'b0, OP_XOR};
          F_NOR:  r = {1'b0, OP_NOR};
          F_SLT:  r = {1'b0, OP_SLT};
          F_SLTU: r = {1'b0, OP_SLTU};
          F_MULT, F_MULTU, F_DIV, F_DIVU: r = {1'b0, OP_ADD};
          default: r = {1'b1, OP_ADD};
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_muldiv_iter.sv
// Iterative unsigned multiply/divide datapath: one shift-add or restoring
// shift-subtract step per cycle, with its own step counter.
module muldiv_iter
  import alu_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             mul,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CW = $clog2(WIDTH);

  logic             mul_q, mul_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Next-state of the shared accumulator/low word for a multiply or divide step
  always_comb begin
    mul_d  = mul_q;
    acc_d  = acc_q;
    low_d  = low_q;
    opd_d  = opd_q;
    cnt_d  = cnt_q;
    sum    = {1'b0, acc_q} + {1'b0, (low_q[0] ? opd_q : '0)};
    rem_sh = {acc_q, low_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, opd_q};
    if (load) begin
      mul_d = mul;
      acc_d = '0;
      low_d = mul ? op_b : op_a;
      opd_d = mul ? op_a : op_b;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      if (mul_q) begin
        {acc_d, low_d} = {sum, low_q[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
        acc_d = diff[WIDTH-1:0];
        low_d = {low_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = rem_sh[WIDTH-1:0];
        low_d = {low_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Datapath registers; loaded at launch, so no reset needed
  always_ff @(posedge clk) begin
    mul_q <= mul_d;
    acc_q <= acc_d;
    low_q <= low_d;
    opd_q <= opd_d;
    cnt_q <= cnt_d;
  end

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign res_hi = acc_q;
  assign res_lo = low_q;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode plus multiply/divide sequencer producing hi/lo results.
module alu_muldiv_ctrl
  import alu_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [OPW-1:0]   alu_operation,
  output logic             illegal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (-v) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic neg, input logic [2*WIDTH-1:0] v);
    return neg ? (-v) : v;
  endfunction

  md_state_e        state_q, state_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             illegal_q, illegal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             op_mul_q, op_mul_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d;

  logic [4:0]       dec;
  logic             is_md, md_mul, md_signed, launch;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             it_step, it_last;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [2*WIDTH-1:0] prod_fix;

  // Registered ALU decode, independent of the sequencer
  always_comb begin
    dec       = alu_decode(aluop, funct);
    illegal_d = dec[4];
    alu_op_d  = OPW'(dec[3:0]);
  end

  // Launch qualification and operand magnitudes
  always_comb begin
    is_md     = (aluop == ALUOP_RTYPE) &&
                (funct == F_MULT || funct == F_MULTU || funct == F_DIV || funct == F_DIVU);
    md_mul    = (funct == F_MULT) || (funct == F_MULTU);
    md_signed = (funct == F_MULT) || (funct == F_DIV);
    launch    = start && (state_q == ST_IDLE) && is_md;
    a_mag     = apply_sign(md_signed && a[WIDTH-1], a);
    b_mag     = apply_sign(md_signed && b[WIDTH-1], b);
  end

  assign it_step  = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign prod_fix = apply_sign_wide(neg_res_q, {it_hi, it_lo});

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .load   (launch),
    .mul    (md_mul),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .step   (it_step),
    .last   (it_last),
    .res_hi (it_hi),
    .res_lo (it_lo)
  );

  // Sequencer next state and result write-back
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    op_mul_d  = op_mul_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    a_d       = a_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          op_mul_d  = md_mul;
          neg_res_d = md_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = md_signed && a[WIDTH-1];
          dz_d      = !md_mul && (b == '0);
          a_d       = a;
          if (md_mul)         state_d = ST_MUL;
          else if (b == '0)   state_d = ST_FIX;
          else                state_d = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (it_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (op_mul_q) begin
          {hi_d, lo_d} = prod_fix;
        end else begin
          hi_d = apply_sign(neg_rem_q, it_hi);
          lo_d = apply_sign(neg_res_q, it_lo);
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs; reset wins over any same-cycle launch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      alu_op_q  <= OPW'(OP_ADD);
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      op_mul_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      op_mul_q  <= op_mul_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  // Captured dividend for the divide-by-zero result
  always_ff @(posedge clk) begin
    a_q <= a_d;
  end

  assign alu_operation = alu_op_q;
  assign illegal       = illegal_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign hi            = hi_q;
  assign lo            = lo_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboard bench for alu_muldiv_ctrl at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic        start;
  logic        sel;
  logic [31:0] a_in, b_in;

  logic        start32, start8;
  logic [3:0]  op32, op8;
  logic        ill32, ill8, busy32, busy8, done32, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  logic [63:0] hi_o, lo_o;
  logic        busy_o, done_o;

  always #5 clk = ~clk;

  assign start32 = start & ~sel;
  assign start8  = start & sel;
  assign hi_o    = sel ? {56'b0, hi8} : {32'b0, hi32};
  assign lo_o    = sel ? {56'b0, lo8} : {32'b0, lo32};
  assign busy_o  = sel ? busy8 : busy32;
  assign done_o  = sel ? done8 : done32;

  alu_muldiv_ctrl #(.WIDTH(32), .OPW(4)) dut32 (
    .clk(clk), .rst(rst), .aluop(aluop), .funct(funct), .start(start32),
    .a(a_in), .b(b_in), .alu_operation(op32), .illegal(ill32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  alu_muldiv_ctrl #(.WIDTH(8), .OPW(4)) dut8 (
    .clk(clk), .rst(rst), .aluop(aluop), .funct(funct), .start(start8),
    .a(a_in[7:0]), .b(b_in[7:0]), .alu_operation(op8), .illegal(ill8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    string       name;
    logic [63:0] hi;
    logic [63:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode taken straight from the operation table
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b11) return 5'b0_0001;
    case (f)
      6'b100000: return 5'b0_0010;
      6'b100010: return 5'b0_0110;
      6'b100100: return 5'b0_0000;
      6'b100101: return 5'b0_0001;
      6'b100110: return 5'b0_0011;
      6'b100111: return 5'b0_1100;
      6'b101010: return 5'b0_0111;
      6'b101011: return 5'b0_1111;
      6'b011000, 6'b011001, 6'b011010, 6'b011011: return 5'b0_0010;
      default: return 5'b1_0010;
    endcase
  endfunction

  // Arithmetic reference built on native 64-bit signed operators
  task automatic model(input int w, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] eh, output logic [63:0] el);
    logic [63:0] m, pv;
    longint ua, ub, sa, sbv, one, q, r;
    m   = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
    one = 1;
    ua  = longint'({32'b0, a} & m);
    ub  = longint'({32'b0, b} & m);
    sa  = a[w-1] ? ua - (one << w) : ua;
    sbv = b[w-1] ? ub - (one << w) : ub;
    eh  = '0;
    el  = '0;
    if (f == 6'b011000 || f == 6'b011001) begin
      pv = (f == 6'b011000) ? 64'(sa * sbv) : 64'(ua * ub);
      eh = (pv >> w) & m;
      el = pv & m;
    end else if (ub == 0) begin
      eh = {32'b0, a} & m;
      el = m;
    end else begin
      if (f == 6'b011010) begin
        q = sa / sbv;
        r = sa % sbv;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      eh = 64'(r) & m;
      el = 64'(q) & m;
    end
  endtask

  task automatic dec_check(input logic [1:0] op, input logic [5:0] f);
    logic [4:0] e;
    e = ref_dec(op, f);
    aluop = op;
    funct = f;
    @(posedge clk); #1;
    check_val($sformatf("dec op %b/%b", op, f), {60'b0, op32}, {60'b0, e[3:0]});
    check_val($sformatf("dec illegal %b/%b", op, f), {63'b0, ill32}, {63'b0, e[4]});
  endtask

  task automatic run_op(input string name, input bit s, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input bit mid_start);
    int          w, lat;
    logic [31:0] m32;
    logic [63:0] eh, el;
    exp_t        e;
    w   = s ? 8 : 32;
    m32 = s ? 32'hFF : 32'hFFFF_FFFF;
    sel = s;
    aluop = 2'b10;
    funct = f;
    a_in  = a & m32;
    b_in  = b & m32;
    model(w, f, a & m32, b & m32, eh, el);
    e.name = name;
    e.hi   = eh;
    e.lo   = el;
    e.lat  = (f[1] && ((b & m32) == 0)) ? 2 : w + 2;
    start  = 1'b1;
    @(posedge clk); #1;
    sb.push_back(e);
    start = 1'b0;
    lat   = 1;
    check_val({name, " busy"}, {63'b0, busy_o}, 64'd1);
    while (!done_o && lat < w + 10) begin
      if (mid_start && lat == 5) begin
        start = 1'b1;
        a_in  = 32'h55 & m32;
        b_in  = 32'h3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    e = sb.pop_front();
    check_val({e.name, " done"}, {63'b0, done_o}, 64'd1);
    check_val({e.name, " latency"}, 64'(lat), 64'(e.lat));
    check_val({e.name, " hi"}, hi_o, e.hi);
    check_val({e.name, " lo"}, lo_o, e.lo);
    @(posedge clk); #1;
    check_val({e.name, " done pulse"}, {63'b0, done_o}, 64'd0);
    check_val({e.name, " idle"}, {63'b0, busy_o}, 64'd0);
    check_val({e.name, " hold lo"}, lo_o, e.lo);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; sel = 1'b0; aluop = 2'b00; funct = 6'd0;
    a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst op32", {60'b0, op32}, 64'h2);
    check_val("rst op8", {60'b0, op8}, 64'h2);
    check_val("rst ctrl32", {60'b0, ill32, busy32, done32, 1'b0}, 64'h0);
    check_val("rst ctrl8", {60'b0, ill8, busy8, done8, 1'b0}, 64'h0);
    check_val("rst hilo32", {hi32, lo32}, 64'h0);
    check_val("rst hilo8", {48'b0, hi8, lo8}, 64'h0);
    rst = 1'b0;

    dec_check(2'b00, 6'b111111);
    dec_check(2'b01, 6'b100000);
    dec_check(2'b11, 6'b111111);
    for (int i = 0; i < 64; i += 3) dec_check(2'b10, 6'(i));
    dec_check(2'b10, 6'b100111);
    dec_check(2'b10, 6'b111111);
    dec_check(2'b10, 6'b100010);
    dec_check(2'b10, 6'b101011);
    dec_check(2'b10, 6'b011011);

    for (int s = 0; s < 2; s++) begin
      logic [31:0] mn;
      mn = (s == 1) ? 32'h80 : 32'h8000_0000;
      run_op("mult -3*7",   s[0], 6'b011000, 32'hFFFF_FFFD, 32'd7, 1'b0);
      if (s == 0) begin
        check_val("mult hi const", {32'b0, hi32}, 64'hFFFF_FFFF);
        check_val("mult lo const", {32'b0, lo32}, 64'hFFFF_FFEB);
      end
      run_op("divu 100/7",  s[0], 6'b011011, 32'd100, 32'd7, 1'b0);
      if (s == 0) check_val("divu lo const", {hi32, lo32}, {32'd2, 32'd14});
      run_op("div -7/2",    s[0], 6'b011010, 32'hFFFF_FFF9, 32'd2, 1'b0);
      if (s == 0) check_val("div const", {hi32, lo32}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op("div 5/0",     s[0], 6'b011010, 32'd5, 32'd0, 1'b0);
      if (s == 0) check_val("div0 const", {hi32, lo32}, {32'd5, 32'hFFFF_FFFF});
      run_op("div min/-1",  s[0], 6'b011010, mn, 32'hFFFF_FFFF, 1'b0);
      if (s == 0) check_val("ovf const", {hi32, lo32}, {32'd0, 32'h8000_0000});
      run_op("multu big",   s[0], 6'b011001, 32'hFFFF_FFF3, 32'hF000_00C5, 1'b0);
      run_op("mult restart", s[0], 6'b011000, 32'h0000_1234, 32'hFFFF_FF9C, 1'b1);
      run_op("divu 0/9",    s[0], 6'b011011, 32'd0, 32'd9, 1'b0);
      run_op("div 9/-4",    s[0], 6'b011010, 32'd9, 32'hFFFF_FFFC, 1'b0);
    end

    // Reset in the middle of a divide
    sel = 1'b0; aluop = 2'b10; funct = 6'b011011; a_in = 32'd100; b_in = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check_val("pre-rst busy", {63'b0, busy32}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst abort busy", {63'b0, busy32}, 64'd0);
    check_val("rst abort hilo", {hi32, lo32}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32 || busy32) seen++;
    end
    check_val("rst abort no done", 64'(seen), 64'd0);

    // Reset takes priority over a same-cycle start
    start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    check_val("rst vs start busy", {63'b0, busy32}, 64'd0);
    @(posedge clk); #1;
    check_val("rst vs start idle", {63'b0, busy32}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_ctrl.md
ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width.
REQ-002 Parameter OPW, default 4: ALU operation code width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 aluop  input  2  main-decoder class: 00 add, 01 sub, 10 R-type funct decode, 11 logical-immediate.
REQ-006 funct  input  6  instruction bits [5:0].
REQ-007 start  input  1  single-cycle request to launch a multiply/divide.
REQ-008 a, b  input  WIDTH each  multiply/divide operands (a = rs, b = rt).
REQ-009 alu_operation  output  OPW  registered ALU operation code.
REQ-010 illegal  output  1  registered flag; high when aluop=10 and funct is not in the decode table.
REQ-011 busy  output  1  high while the sequencer is not IDLE.
REQ-012 done  output  1  one-cycle pulse; hi/lo are valid when it is high.
REQ-013 hi, lo  output  WIDTH each  result registers; hold their value until the next completion.

Function
REQ-014 Decode SHALL be registered: alu_operation/illegal reflect the inputs sampled at the previous clock edge (1-cycle latency).
REQ-015 aluop=00 SHALL give 0010; 01 SHALL give 0110; 11 SHALL give 0001 with funct ignored.
REQ-016 aluop=10 SHALL map funct to op: 100000 0010, 100010 0110, 100100 0000, 100101 0001, 100110 0011, 100111 1100, 101010 0111, 101011 1111.
REQ-017 aluop=10 with funct 011000-011011 SHALL give 0010 with illegal=0; any other unlisted funct SHALL give 0010 with illegal=1 (never X).
REQ-018 FSM states: IDLE, MUL, DIV, FIX, DONE.
REQ-019 From IDLE, start=1 with aluop=10 SHALL launch an operation: funct 011000 (mult) or 011001 (multu) -> MUL; funct 011010 (div) or 011011 (divu) -> DIV. start with any other aluop/funct SHALL be ignored.
REQ-020 At launch, operands SHALL be captured; for signed ops, magnitudes are captured and the result signs recorded.
REQ-021 MUL SHALL run a shift-add over exactly WIDTH cycles, then go to FIX.
REQ-022 DIV SHALL run a restoring shift-subtract over exactly WIDTH cycles, then go to FIX.
REQ-023 FIX (1 cycle) SHALL apply signs, then write hi/lo:
- mult: {hi,lo} = product.
- div: lo = quotient, hi = remainder; remainder takes the sign of a.
REQ-024 DONE SHALL assert done for 1 cycle, then return to IDLE.
REQ-025 Latency: done SHALL be high exactly WIDTH+2 cycles after the launch edge; busy SHALL be high from the cycle after launch through the DONE cycle.
REQ-026 Divide by zero (b=0 at launch) SHALL bypass DIV: go directly to FIX, set hi=a and lo=all ones, and complete at launch+2.
REQ-027 start while busy SHALL be ignored; in-flight operands are unaffected.
REQ-028 Signed overflow (div of the most-negative value by -1) SHALL give lo = most-negative value, hi = 0.
REQ-029 Decode (REQ-014..017) SHALL continue every cycle regardless of sequencer state.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, alu_operation=0010, illegal=0, busy=0, done=0, hi=0, lo=0.
REQ-031 rst mid-operation SHALL abort the operation with no done pulse; reset takes priority over a same-cycle start.

Structure
REQ-032 The funct codes, aluop encodings, OPW operation codes and FSM state encodings SHALL live in a shared package used by the main control unit and the ALU.
REQ-033 The iterative datapath SHALL be the sub-module muldiv_iter (step counter, shift registers, add/sub); alu_muldiv_ctrl holds the decode and the FSM.

Verification
REQ-034 aluop=10, funct=100111 -> next cycle alu_operation=1100, illegal=0; funct=111111 -> 0010, illegal=1.
REQ-035 mult a=-3, b=7 with start -> done at launch+34 (WIDTH=32); hi=FFFFFFFF, lo=FFFFFFEB.
REQ-036 divu a=100, b=7 -> lo=14, hi=2; div a=-7, b=2 -> lo=-3, hi=-1.
REQ-037 div a=5, b=0 -> done at launch+2; hi=5, lo=FFFFFFFF.
REQ-038 start pulsed again mid-MUL -> ignored, original result correct; rst at cycle 10 of DIV -> busy=0 next cycle, no done, hi=lo=0.
REQ-039 div a=80000000, b=FFFFFFFF -> lo=80000000, hi=0; repeat the directed tests with WIDTH=8.
